// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock and baud
// constants, and the bit-time helper used by both receiver and transmitter.
package uart_pkg;

    localparam int DEFAULT_CLOCK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD_RATE  = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_t;

    // Clocks per serial bit, rounded to nearest.
    function automatic int calc_bit_time(input int clock_freq,
                                         input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 1.
// Ports: clk, rst (async high), d (async in), q (synchronized out).
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte valid/ready output buffer.
// Ports: clk, rst (async high), serial_in, data_out/data_out_valid/
// data_out_ready (byte handshake), framing_error and overrun (1-cycle pulses).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int BIT_TIME = calc_bit_time(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT = BIT_TIME / 2;
    localparam int CW       = $clog2(BIT_TIME);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_TIME - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    logic        rx;
    uart_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    synchronizer #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // Consumer drain; a delivery below may override it.
            if (data_out_valid && data_out_ready)
                data_out_valid <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // High at mid start bit is a glitch.
                        state   <= rx ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= ST_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx) begin
                            state <= ST_IDLE;
                            if (!data_out_valid || data_out_ready) begin
                                data_out       <= shreg;
                                data_out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            state         <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in baud.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port serial_in, input, 1 bit: asynchronous serial line (idle high, 8N1, LSB first).
REQ-006 Port data_out, output, 8 bits: received byte.
REQ-007 Port data_out_valid, output, 1 bit: data_out holds an unconsumed byte.
REQ-008 Port data_out_ready, input, 1 bit: consumer accepts data_out this cycle.
REQ-009 Port framing_error, output, 1 bit: one-cycle pulse when a stop bit samples low.
REQ-010 Port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-011 BIT_TIME SHALL be CLOCK_FREQ/BAUD_RATE rounded to nearest (434 at defaults); HALF_BIT SHALL be BIT_TIME/2 (217).
REQ-012 serial_in SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized line only.
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: a synchronized low SHALL move to START with the cycle counter cleared.
REQ-015 START: at HALF_BIT cycles, low → DATA (counter cleared, bit index 0); high → IDLE (glitch rejected, no outputs).
REQ-016 DATA: every BIT_TIME cycles, sample the line into bit[index], LSB first; after bit 7 → STOP.
REQ-017 STOP: at BIT_TIME cycles, sample; high → deliver byte and → IDLE; low → framing_error pulse, byte discarded, → WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL remain until the synchronized line is high, then → IDLE.
REQ-019 Delivery: data_out_valid SHALL rise on the edge following the stop-bit sample cycle, with data_out loaded the same edge.
REQ-020 Delivery SHALL succeed if data_out_valid is 0, or if data_out_valid and data_out_ready are both 1 in the delivery cycle (simultaneous drain and load: valid stays 1, new byte loaded).
REQ-021 Otherwise the new byte SHALL be dropped, the buffered byte kept, and overrun pulse for one cycle.
REQ-022 data_out SHALL be stable while data_out_valid is 1; data_out_valid SHALL clear on the edge after data_out_valid and data_out_ready are both 1, unless REQ-020 reloads.
REQ-023 data_out_ready while data_out_valid is 0 SHALL have no effect.
REQ-024 Back-to-back frames (start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-025 While rst is high: data_out=0, data_out_valid=0, framing_error=0, overrun=0, state=IDLE, counters=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no partial byte and no error pulse.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state encoding and the default CLOCK_FREQ/BAUD_RATE constants, reused by the future transmitter.
REQ-028 The 2-flop synchronizer SHALL be a sub-module named synchronizer (parameterized width, reset value 1).

Verification (defaults, 434 cycles/bit)
REQ-029 Frame 0xA5, ready=1 → data_out=0xA5, valid high 1 cycle, no error pulses.
REQ-030 ready=0, frames 0x3C then 0x55 → data_out stays 0x3C, one overrun pulse at the second stop sample; ready=1 → valid drops next edge.
REQ-031 Frame 0xFF with stop bit low, line held low 20 bit times → one framing_error pulse, no valid; then frame 0x12 → data_out=0x12.
REQ-032 Low glitch of 100 cycles → no valid, no error, FSM back in IDLE; next frame 0x7E received.
REQ-033 rst pulse during data bit 4 → all outputs 0 immediately, no valid; after release, frame 0x81 → data_out=0x81.
REQ-034 Back-to-back frames 0x00, 0xFF with ready=1 → two valid pulses, in order.
